// File: rtl/cw305_cmd_seq.sv
// ---------------------------------------------------------------------------
// cw305_cmd_seq
//
// Command sequencer between the ChipWhisperer USB register block and a
// CPU-side AXI mailbox. A start strobe latches a 128-bit key and a 128-bit
// plaintext, streams them out as eight 32-bit words (key words 0..3 first,
// low word first, then plaintext words 0..3), then collects four 32-bit
// result words and publishes them on ct in one step together with a
// one-cycle done pulse. A watchdog aborts a stalled transfer and raises a
// sticky err flag.
//
// Ports
//   clk                     sole clock, rising edge
//   resetn                  asynchronous active-low reset
//   start                   one-cycle command strobe (honoured only when idle)
//   key, pt      [127:0]    key / plaintext, sampled on an accepted start
//   ct           [127:0]    ciphertext result register
//   busy                    command in progress
//   done                    one-cycle completion pulse
//   err                     sticky timeout flag, cleared by the next start
//   tx_valid/tx_ready/tx_data[31:0]   word stream toward the mailbox
//   rx_valid/rx_ready/rx_data[31:0]   result word stream from the mailbox
//
// Parameter
//   TIMEOUT   cycles without a handshake in SEND/RECV before abort (0 = off)
// ---------------------------------------------------------------------------
module cw305_cmd_seq #(
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] pt,
  output logic [127:0] ct,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [31:0]  tx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  input  logic [31:0]  rx_data
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_RECV = 2'd2;

  logic [1:0]   r_state;
  logic [255:0] r_msg;        // {pt, key}: word i of the outgoing stream is r_msg[32i +: 32]
  logic [2:0]   r_idx;        // word index, shared by SEND (0..7) and RECV (0..3)
  logic [31:0]  r_cnt;        // cycles since the last handshake
  logic [31:0]  r_shadow [3]; // result words 0..2; word 3 goes straight to ct
  logic [127:0] r_ct;
  logic         r_busy;
  logic         r_done;
  logic         r_err;
  logic         r_tx_valid;
  logic [31:0]  r_tx_data;
  logic         r_rx_ready;

  logic         w_tx_hs;
  logic         w_rx_hs;
  logic         w_timeout;
  logic [2:0]   w_next_idx;

  assign w_tx_hs    = r_tx_valid && tx_ready;
  assign w_rx_hs    = r_rx_ready && rx_valid;
  assign w_next_idx = r_idx + 3'd1;

  // Abort on the edge where the idle count would reach TIMEOUT, so err/busy
  // change exactly TIMEOUT cycles after the last handshake.
  assign w_timeout  = (TIMEOUT != 0) && ((r_cnt + 32'd1) == TIMEOUT);

  // NOTE: all state below is written with non-blocking assignments so every
  // register sees the pre-edge values of its neighbours, whatever the order
  // of statements inside the block.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_msg      <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      // NOTE: the shadow array is only three words, so it is reset with the
      // rest of the state rather than left as uninitialised storage.
      for (int i = 0; i < 3; i++) r_shadow[i] <= '0;
      r_ct       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_rx_ready <= 1'b0;
    end else begin
      r_done <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_msg      <= {pt, key};
            r_err      <= 1'b0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_tx_valid <= 1'b1;
            r_tx_data  <= key[31:0];
            r_state    <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (w_tx_hs) begin
            r_cnt <= '0;
            if (r_idx == 3'd7) begin
              r_idx      <= '0;
              r_tx_valid <= 1'b0;
              r_tx_data  <= '0;
              r_rx_ready <= 1'b1;
              r_state    <= ST_RECV;
            end else begin
              r_idx     <= w_next_idx;
              r_tx_data <= r_msg[{w_next_idx, 5'd0} +: 32];
            end
          end else if (w_timeout) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b1;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_state    <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end

        ST_RECV: begin
          if (w_rx_hs) begin
            r_cnt <= '0;
            if (r_idx == 3'd3) begin
              // Whole result lands on ct at once; partial words never show.
              r_ct       <= {rx_data, r_shadow[2], r_shadow[1], r_shadow[0]};
              r_done     <= 1'b1;
              r_busy     <= 1'b0;
              r_rx_ready <= 1'b0;
              r_idx      <= '0;
              r_state    <= ST_IDLE;
            end else begin
              r_shadow[r_idx[1:0]] <= rx_data;
              r_idx                <= w_next_idx;
            end
          end else if (w_timeout) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b1;
            r_rx_ready <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ct       = r_ct;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
  assign rx_ready = r_rx_ready;

endmodule

// File: tb/tb_cw305_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_cw305_cmd_seq
//
// Directed scenarios (basic, timeout, backpressure, back-to-back start,
// start while busy, reset mid-send) followed by a randomised run. Every
// cycle the DUT outputs are compared against a transaction-level model that
// tracks words sent, words received and idle cycles since the last
// handshake.
// ---------------------------------------------------------------------------
module tb_cw305_cmd_seq;

  localparam int unsigned TMO = 16;

  logic         clk;
  logic         resetn;
  logic         start;
  logic [127:0] key;
  logic [127:0] pt;
  logic [127:0] ct;
  logic         busy;
  logic         done;
  logic         err;
  logic         tx_valid;
  logic         tx_ready;
  logic [31:0]  tx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic [31:0]  rx_data;

  cw305_cmd_seq #(.TIMEOUT(TMO)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .key      (key),
    .pt       (pt),
    .ct       (ct),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_data  (rx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: command-level bookkeeping.
  logic [31:0]  m_words [8];
  logic [31:0]  m_got   [4];
  int           m_sent;
  int           m_rcvd;
  int           m_quiet;
  logic         m_busy;
  logic         m_done;
  logic         m_err;
  logic [127:0] m_ct;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sent  = 0;
    m_rcvd  = 0;
    m_quiet = 0;
    m_busy  = 1'b0;
    m_done  = 1'b0;
    m_err   = 1'b0;
    m_ct    = '0;
  endtask

  // Called at a falling edge: drive inputs, compare the outputs produced by
  // the previous rising edge with the model, advance the model by one edge,
  // then move on to the next falling edge.
  task automatic step(input logic s, input logic tr, input logic rv, input logic [31:0] rd);
    logic hs;
    start    = s;
    tx_ready = tr;
    rx_valid = rv;
    rx_data  = rd;

    check("busy",     busy,     m_busy);
    check("done",     done,     m_done);
    check("err",      err,      m_err);
    check("ct",       ct,       m_ct);
    check("tx_valid", tx_valid, m_busy && m_sent < 8);
    check("rx_ready", rx_ready, m_busy && m_sent == 8);
    if (m_busy && m_sent < 8) check("tx_data", tx_data, m_words[m_sent]);

    m_done = 1'b0;
    if (!m_busy) begin
      if (s) begin
        for (int i = 0; i < 4; i++) begin
          m_words[i]     = key[32*i +: 32];
          m_words[i + 4] = pt[32*i +: 32];
        end
        m_sent  = 0;
        m_rcvd  = 0;
        m_quiet = 0;
        m_busy  = 1'b1;
        m_err   = 1'b0;
      end
    end else begin
      hs = (m_sent < 8) ? tr : rv;
      if (hs) begin
        m_quiet = 0;
        if (m_sent < 8) begin
          m_sent++;
        end else begin
          m_got[m_rcvd] = rd;
          m_rcvd++;
          if (m_rcvd == 4) begin
            m_ct   = {m_got[3], m_got[2], m_got[1], m_got[0]};
            m_busy = 1'b0;
            m_done = 1'b1;
          end
        end
      end else begin
        m_quiet++;
        if (m_quiet == int'(TMO)) begin
          m_busy = 1'b0;
          m_err  = 1'b1;
        end
      end
    end

    @(posedge clk);
    @(negedge clk);
  endtask

  // Assert reset between edges and check the outputs clear without a clock.
  task automatic pulse_reset();
    start    = 1'b0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    resetn   = 1'b0;
    #1;
    check("rst_ct",       ct,       128'd0);
    check("rst_busy",     busy,     1'b0);
    check("rst_done",     done,     1'b0);
    check("rst_err",      err,      1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_rx_ready", rx_ready, 1'b0);
    check("rst_tx_data",  tx_data,  32'd0);
    model_reset();
    #2;
    resetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive full-throughput handshakes until the model goes idle (bounded).
  task automatic finish_cmd(input int limit);
    int k;
    k = 0;
    while (m_busy && k < limit) begin
      step(1'b0, 1'b1, 1'b1, $urandom);
      k++;
    end
    check("cmd_bounded", m_busy, 1'b0);
  endtask

  initial begin
    int n;
    int pulses;
    logic [127:0] ct_before;

    resetn   = 1'b0;
    start    = 1'b0;
    key      = '0;
    pt       = '0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    model_reset();
    @(negedge clk);
    pulse_reset();

    // Basic command, full throughput.
    key = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    pt  = 128'hffeeddcc_bbaa9988_77665544_33221100;
    step(1'b1, 1'b1, 1'b1, 32'd0);
    check("basic_word0", tx_data, 32'h03020100);
    n = 1;
    while (n < 40 && !done) begin
      step(1'b0, 1'b1, 1'b1, 32'(32'h11111111 * (m_rcvd + 1)));
      n++;
    end
    check("basic_latency", n, 13);
    check("basic_ct", ct, 128'h44444444_33333333_22222222_11111111);
    step(1'b0, 1'b1, 1'b1, 32'd0);

    // Timeout: words 0..3 go through, then tx_ready stays low.
    ct_before = ct;
    key = {$urandom, $urandom, $urandom, $urandom};
    step(1'b1, 1'b1, 1'b1, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'd0);
    n = 0;
    while (n < 40 && busy) begin
      step(1'b0, 1'b0, 1'b0, 32'd0);
      n++;
    end
    check("tmo_cycles", n, 16);
    check("tmo_err", err, 1'b1);
    check("tmo_ct_kept", ct, ct_before);
    step(1'b0, 1'b0, 1'b0, 32'd0);

    // Backpressure: tx_ready toggles, rx_valid high one cycle in four.
    key = {$urandom, $urandom, $urandom, $urandom};
    pt  = {$urandom, $urandom, $urandom, $urandom};
    step(1'b1, 1'b0, 1'b0, 32'd0);
    n = 0;
    pulses = 0;
    while (n < 200 && !done) begin
      step(1'b0, n[0], (n % 4) == 3, $urandom);
      n++;
    end
    check("bp_done_seen", done, 1'b1);
    check("bp_err_clear", err, 1'b0);

    // Back-to-back: start in the done cycle.
    key = {$urandom, $urandom, $urandom, $urandom};
    pt  = {$urandom, $urandom, $urandom, $urandom};
    step(1'b1, 1'b1, 1'b1, 32'd0);
    check("b2b_busy", busy, 1'b1);
    check("b2b_err", err, 1'b0);
    check("b2b_done_once", done, 1'b0);
    finish_cmd(40);
    step(1'b0, 1'b0, 1'b0, 32'd0);

    // Start while busy: new key during SEND, new pt during RECV.
    key = 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef;
    pt  = 128'hfedc_ba98_7654_3210_fedc_ba98_7654_3210;
    step(1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    key = ~key;
    step(1'b1, 1'b1, 1'b0, 32'd0);
    while (m_sent < 8) step(1'b0, 1'b1, 1'b0, 32'd0);
    pt = ~pt;
    step(1'b1, 1'b0, 1'b1, 32'hA5A5_0001);
    check("sb_rx_ready", rx_ready, 1'b1);
    check("sb_tx_valid", tx_valid, 1'b0);
    finish_cmd(40);
    step(1'b0, 1'b0, 1'b0, 32'd0);

    // Reset mid-SEND after word 5, then a clean command.
    step(1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 32'd0);
    pulse_reset();
    step(1'b0, 1'b1, 1'b1, 32'd0);
    key = {$urandom, $urandom, $urandom, $urandom};
    step(1'b1, 1'b1, 1'b1, 32'd0);
    finish_cmd(40);
    check("post_rst_err", err, 1'b0);
    check("post_rst_done", done, 1'b1);

    // Randomised traffic, random start strobes and changing operands.
    for (int c = 0; c < 600; c++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      step(($urandom % 8) == 0, ($urandom % 4) != 0, ($urandom % 3) == 0, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
